// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// registered result and handshake out.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             OVF;
  logic             busy;
  logic             done;

  modport master (output start, A, B, cin, sub, input  S, C, OVF, busy, done);
  modport slave  (input  start, A, B, cin, sub, output S, C, OVF, busy, done);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus carry flop, LSB first,
// WIDTH+1 cycles from start to done.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d, c_q, c_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, carry_nxt, load;

  always_comb begin
    sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    // A request is only accepted outside ADD, so DONE can reload back-to-back.
    load      = bus.start && (state_q != ADD);
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          state_d = ADD;
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ADD: begin
        acc_d   = (acc_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          s_d     = acc_d;
          c_d     = carry_nxt;
          // carry_q here is the carry into the MSB cell
          ovf_d   = carry_q ^ carry_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.S    = s_q;
  assign bus.C    = c_q;
  assign bus.OVF  = ovf_q;
  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed table, corner sequences and random ops
// against an integer-arithmetic model, on WIDTH=4 and WIDTH=1 instances.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(4)) b4();
  serial_adder_if #(.WIDTH(1)) b1();

  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint a, b;
    bit     cin, sub;
    longint s;
    bit     c, ovf;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: unsigned sum for S/C, true signed result range for OVF.
  function automatic void model(input int w, input longint a_in, input longint b_in,
                                input bit cin, input bit sub,
                                output longint s, output bit c, output bit ovf);
    longint m, a, b, sum, lim, sa, sb, r;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    a   = a_in & m;
    b   = b_in & m;
    sum = sub ? a + ((~b) & m) + 1 : a + b + longint'(cin);
    s   = sum & m;
    c   = ((sum >> w) & 1) != 0;
    sa  = (a >= lim) ? a - 2 * lim : a;
    sb  = (b >= lim) ? b - 2 * lim : b;
    r   = sub ? sa - sb : sa + sb + longint'(cin);
    ovf = (r < -lim) || (r >= lim);
  endfunction

  task automatic drive(input int w, input bit st, input longint a, input longint b,
                       input bit cin, input bit sub);
    if (w == 4) begin
      b4.start = st; b4.A = a[3:0]; b4.B = b[3:0]; b4.cin = cin; b4.sub = sub;
    end else begin
      b1.start = st; b1.A = a[0:0]; b1.B = b[0:0]; b1.cin = cin; b1.sub = sub;
    end
  endtask

  task automatic sample(input int w, output longint s, output bit c, output bit ovf,
                        output bit busy, output bit done);
    if (w == 4) begin
      s = longint'(b4.S); c = b4.C; ovf = b4.OVF; busy = b4.busy; done = b4.done;
    end else begin
      s = longint'(b1.S); c = b1.C; ovf = b1.OVF; busy = b1.busy; done = b1.done;
    end
  endtask

  // Called at a negedge; returns at the negedge after the done pulse.
  task automatic run_op(input int w, input longint a, input longint b, input bit cin,
                        input bit sub, input string tag,
                        output longint s, output bit c, output bit ovf);
    longint es; bit ec, eo, bsy, dn; int n;
    model(w, a, b, cin, sub, es, ec, eo);
    drive(w, 1'b1, a, b, cin, sub);
    n = 0;
    for (int i = 1; i <= 3 * w + 10; i++) begin
      @(negedge clk);
      sample(w, s, c, ovf, bsy, dn);
      if (i == 1) begin
        chk({tag, " busy"}, longint'(bsy), 1);
        // operands must be ignored after the load edge
        drive(w, 1'b0, longint'($urandom), longint'($urandom), 1'($urandom), 1'($urandom));
      end
      if (dn) begin n = i; break; end
    end
    chk({tag, " latency"}, n, w + 1);
    chk({tag, " S"}, s, es);
    chk({tag, " C"}, longint'(c), longint'(ec));
    chk({tag, " OVF"}, longint'(ovf), longint'(eo));
    @(negedge clk);
    sample(w, es, ec, eo, bsy, dn);
    chk({tag, " done pulse"}, longint'(dn), 0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    longint s; bit c, o, bsy, dn;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample(4, s, c, o, bsy, dn);
      if (dn) cnt++;
    end
  endtask

  initial begin
    vec_t   tbl[5];
    longint s, es, ra, rb;
    bit     c, o, bsy, dn, ec, eo;
    int     cnt;
    longint opa[16], opb[16];
    bit     opc[16], ops[16];

    tbl[0] = '{a: 5,  b: 3, cin: 0, sub: 0, s: 8,  c: 0, ovf: 1};
    tbl[1] = '{a: 15, b: 1, cin: 0, sub: 0, s: 0,  c: 1, ovf: 0};
    tbl[2] = '{a: 15, b: 1, cin: 1, sub: 0, s: 1,  c: 1, ovf: 0};
    tbl[3] = '{a: 3,  b: 5, cin: 1, sub: 1, s: 14, c: 0, ovf: 0};
    tbl[4] = '{a: 8,  b: 1, cin: 0, sub: 1, s: 7,  c: 1, ovf: 1};

    drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sample(4, s, c, o, bsy, dn);
    chk("rst4 S", s, 0); chk("rst4 C", longint'(c), 0); chk("rst4 OVF", longint'(o), 0);
    chk("rst4 busy", longint'(bsy), 0); chk("rst4 done", longint'(dn), 0);
    sample(1, s, c, o, bsy, dn);
    chk("rst1 busy", longint'(bsy), 0); chk("rst1 done", longint'(dn), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(4, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, $sformatf("vec%0d", i), s, c, o);
      chk($sformatf("vec%0d tbl S", i), s, tbl[i].s);
      chk($sformatf("vec%0d tbl C", i), longint'(c), longint'(tbl[i].c));
      chk($sformatf("vec%0d tbl OVF", i), longint'(o), longint'(tbl[i].ovf));
    end

    // start held high with operands changing every cycle
    foreach (opa[j]) begin
      opa[j] = longint'($urandom_range(15)); opb[j] = longint'($urandom_range(15));
      opc[j] = 1'($urandom); ops[j] = 1'($urandom);
    end
    for (int j = 0; j <= 15; j++) begin
      if (j > 0) begin
        sample(4, s, c, o, bsy, dn);
        chk($sformatf("b2b done@%0d", j), longint'(dn), longint'(j % 5 == 0));
        if (dn) begin
          model(4, opa[j-5], opb[j-5], opc[j-5], ops[j-5], es, ec, eo);
          chk($sformatf("b2b S@%0d", j), s, es);
          chk($sformatf("b2b C@%0d", j), longint'(c), longint'(ec));
          chk($sformatf("b2b OVF@%0d", j), longint'(o), longint'(eo));
        end
      end
      drive(4, j < 15, opa[j], opb[j], opc[j], ops[j]);
      @(negedge clk);
      j = j; // keep loop body uniform; sampling happens at the top
    end

    // start pulse while busy is neither honoured nor queued
    drive(4, 1'b1, 6, 7, 1'b0, 1'b0);
    @(negedge clk); drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk); drive(4, 1'b1, 1, 1, 1'b0, 1'b1);
    @(negedge clk); drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    sample(4, s, c, o, bsy, dn);
    chk("ign done", longint'(dn), 1);
    chk("ign S", s, 13);
    chk("ign OVF", longint'(o), 1);
    count_dones(10, cnt);
    chk("ign extra dones", cnt, 0);

    // reset during the 2nd ADD cycle discards the operation
    run_op(4, 5, 3, 1'b0, 1'b0, "pre-rst", s, c, o);
    drive(4, 1'b1, 15, 1, 1'b0, 1'b0);
    @(negedge clk); drive(4, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sample(4, s, c, o, bsy, dn);
    chk("mrst busy", longint'(bsy), 0); chk("mrst done", longint'(dn), 0);
    chk("mrst S", s, 0); chk("mrst C", longint'(c), 0); chk("mrst OVF", longint'(o), 0);
    count_dones(10, cnt);
    chk("mrst no done", cnt, 0);
    run_op(4, 9, 12, 1'b1, 1'b0, "post-rst", s, c, o);

    for (int k = 0; k < 40; k++) begin
      ra = longint'($urandom_range(15)); rb = longint'($urandom_range(15));
      run_op(4, ra, rb, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", k), s, c, o);
    end

    run_op(1, 1, 1, 1'b1, 1'b0, "w1", s, c, o);
    chk("w1 tbl S", s, 1);
    chk("w1 tbl C", longint'(c), 1);
    for (int k = 0; k < 16; k++)
      run_op(1, longint'(k & 1), longint'((k >> 1) & 1), 1'((k >> 2) & 1), 1'((k >> 3) & 1),
             $sformatf("w1c%0d", k), s, c, o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor built around one full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first.
- Successor to the gate-level half adder: operand width is generalised, plus carry-in, a subtract mode, a start/busy/done handshake and signed overflow detection.
- Used as the area-minimal arithmetic unit in the lab datapath.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only when the block is idle or done is high.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in, used when sub=0.
- sub  input  1  0 selects A+B+cin; 1 selects A-B, i.e. A+~B+1, with cin ignored.
- S  output  WIDTH  result register.
- C  output  1  carry-out; when sub=1 this is not-borrow (1 means A>=B unsigned).
- OVF  output  1  signed overflow of the operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S, C and OVF become valid.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: when rst_n=0 at a rising edge, the block goes to IDLE. S=0, C=0, OVF=0, busy=0, done=0, and all internal shift registers, carry and counter clear. This applies in any state, including mid-operation; the in-flight result is discarded and done is not pulsed.
- FSM states:
  - IDLE: waiting for a request.
  - ADD: one bit processed per clock.
  - DONE: one cycle long.
- IDLE -> ADD when start=1 at an edge.
  - Load: opA = A; opB = B, or ~B when sub=1; carry = cin, or 1 when sub=1; bit counter = 0.
  - Outputs: busy goes to 1. S, C and OVF keep their previous values until completion.
- ADD, each edge:
  - Compute sum = opA[0] ^ opB[0] ^ carry.
  - Compute carry_next = majority(opA[0], opB[0], carry).
  - Shift sum into the MSB of the result shift register; shift opA and opB right by one.
  - Update carry and increment the counter.
- ADD -> DONE on the edge that processes bit WIDTH-1. On that edge:
  - S takes the full result.
  - C = final carry.
  - OVF = carry into MSB XOR carry out of MSB.
  - busy goes to 0; done goes to 1.
- DONE -> IDLE on the next edge if start=0, and done drops.
- DONE -> ADD if start=1, giving back-to-back operation with no idle gap.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH, so WIDTH+1 edges in total. Throughput is one result per WIDTH+1 cycles.
- Inputs A, B, cin and sub are sampled only on the load edge. Changes during ADD have no effect.
- start=1 while busy=1 is ignored and not queued.
- For WIDTH=1 the ADD state lasts exactly one edge.
- Counter width is clog2(WIDTH+1). The counter wraps only through reload, never free-runs.
- S, C and OVF hold their values indefinitely until the next completion or reset.

Test Plan:
- WIDTH=4, start with A=0101, B=0011, cin=0, sub=0 -> busy high for 4 cycles; done pulses one cycle after the 4th ADD edge with S=1000, C=0, OVF=1 (5+3 overflows signed 4-bit).
- A=1111, B=0001, cin=0, sub=0 -> S=0000, C=1, OVF=0. Same operands with cin=1 -> S=0001, C=1.
- sub=1, A=0011, B=0101 -> S=1110, C=0 (borrow), OVF=0. sub=1, A=1000, B=0001 -> S=0111, C=1, OVF=1.
- start held high continuously with changing operands -> consecutive done pulses exactly 5 cycles apart. Operands changed mid-operation do not affect the result; start pulses while busy produce no extra operations.
- Assert rst_n=0 for one edge during the 2nd ADD cycle -> next cycle has busy=0, done=0, S=0, C=0, OVF=0, and no done pulse follows. A new start afterwards completes normally.
- WIDTH=1 instance, A=1, B=1, cin=1 -> done on the 2nd edge after start with S=1, C=1.
